control_sequencer: RTL and testbench

Hardwired control unit for the single-bus CPU DataPath. It sequences the datapath through instruction fetch (T0–T2) and execute (T3–T6) for register-register ALU instructions, driving the same strobes the DataPath exposes, including the bus-out selects, register loads, the 5-bit ALU op and the memory Read. It sits beside the DataPath, reads the IR contents back, and handshakes with memory through a ready input.

---
 rtl/cpu_ctrl_pkg.sv | 66 ++++++
 rtl/control_sequencer_reg_select.sv | 33 +++
 rtl/control_sequencer.sv | 173 +++++++++++++++++
 tb/tb_control_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: IR field
// positions, opcode encodings, the sequencer state enum and opcode
// classification helpers.
package cpu_ctrl_pkg;

  localparam int unsigned IR_W        = 32;
  localparam int unsigned OP_W        = 5;
  localparam int unsigned REG_FIELD_W = 4;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  function automatic logic is_binary(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_halt(input logic [OP_W-1:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// One-hot general-register select decode.
//   ra/rb/rc     : register fields from IR
//   rout_sel_rc  : 0 drives Rout from rb, 1 from rc
//   rin_en       : load ra (R0 is hardwired zero, so Rin[0] never asserts)
//   rout_en      : drive the selected register onto the bus
//   rin/rout     : one-hot load / bus-drive vectors
module reg_select
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = 16
) (
  input  logic [REG_FIELD_W-1:0] ra,
  input  logic [REG_FIELD_W-1:0] rb,
  input  logic [REG_FIELD_W-1:0] rc,
  input  logic                   rout_sel_rc,
  input  logic                   rin_en,
  input  logic                   rout_en,
  output logic [NREGS-1:0]       rin,
  output logic [NREGS-1:0]       rout
);

  always_comb begin
    rin  = '0;
    rout = '0;
    if (rout_en) begin
      rout = rout_sel_rc ? (NREGS'(1) << rc) : (NREGS'(1) << rb);
    end
    if (rin_en && (ra != '0)) begin
      rin = NREGS'(1) << ra;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus CPU datapath. Sequences
// fetch (T0-T2) and execute (T3-T6) of register-register ALU ops.
//   Clock, Clear   : clock, async active-low reset (forces IDLE)
//   IR, MemReady   : instruction register readback, memory data valid
//   PCout..MDRout  : bus-drive selects; Rout one-hot register drive
//   MARin..LOin    : register load enables; Rin one-hot register load
//   IncPC, Read    : PC increment, memory read
//   ALUop          : IR opcode during T4, else 0
//   Run, Illegal   : low when halted; one-cycle pulse on undefined opcode
// Strobes are a combinational decode of the state register plus IR.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = 16,
  parameter int unsigned OPW   = 5
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [31:0]      IR,
  input  logic             MemReady,
  output logic             PCout,
  output logic             Zlowout,
  output logic             ZHighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             ZLowIn,
  output logic             ZHighIn,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [NREGS-1:0] Rout,
  output logic [NREGS-1:0] Rin,
  output logic [OPW-1:0]   ALUop,
  output logic             Run,
  output logic             Illegal
);

  state_e state_q, state_d;

  logic [OP_W-1:0]        op;
  logic [REG_FIELD_W-1:0] ra, rb, rc;
  logic                   rin_en, rout_en, rout_sel_rc;
  logic                   unused_ir_bits;

  assign op = IR[OP_MSB:OP_LSB];
  assign ra = IR[RA_MSB:RA_LSB];
  assign rb = IR[RB_MSB:RB_LSB];
  assign rc = IR[RC_MSB:RC_LSB];
  assign unused_ir_bits = ^IR[RC_LSB-1:0];

  // State register
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and strobe decode
  always_comb begin
    state_d     = state_q;
    PCout       = 1'b0;
    Zlowout     = 1'b0;
    ZHighout    = 1'b0;
    MDRout      = 1'b0;
    MARin       = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    ZLowIn      = 1'b0;
    ZHighIn     = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    IncPC       = 1'b0;
    Read        = 1'b0;
    ALUop       = '0;
    Run         = 1'b1;
    Illegal     = 1'b0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_sel_rc = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_T0;

      ST_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        state_d = ST_T1;
      end

      // Hold the read until memory reports valid data
      ST_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (MemReady) state_d = ST_T2;
      end

      ST_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = ST_T3;
      end

      ST_T3: begin
        if (is_binary(op) || is_muldiv(op)) begin
          rout_en = 1'b1;
          Yin     = 1'b1;
          state_d = ST_T4;
        end else if (is_unary(op)) begin
          state_d = ST_T4;
        end else if (is_halt(op)) begin
          Run     = 1'b0;
          state_d = ST_HALT;
        end else begin
          Illegal = 1'b1;
          state_d = ST_T0;
        end
      end

      // Second operand: rc for two-operand ops, rb for unary
      ST_T4: begin
        rout_en     = 1'b1;
        rout_sel_rc = !is_unary(op);
        ALUop       = OPW'(op);
        ZLowIn      = 1'b1;
        ZHighIn     = is_muldiv(op);
        state_d     = ST_T5;
      end

      // Mul/div results go to LO/HI rather than the register file
      ST_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv(op)) begin
          LOin    = 1'b1;
          state_d = ST_T6;
        end else begin
          rin_en  = 1'b1;
          state_d = ST_T0;
        end
      end

      ST_T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
        state_d  = ST_T0;
      end

      ST_HALT: Run = 1'b0;

      default: state_d = ST_IDLE;
    endcase
  end

  reg_select #(
    .NREGS (NREGS)
  ) u_reg_select (
    .ra          (ra),
    .rb          (rb),
    .rc          (rc),
    .rout_sel_rc (rout_sel_rc),
    .rin_en      (rin_en),
    .rout_en     (rout_en),
    .rin         (Rin),
    .rout        (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: each instruction is expanded
// into its expected per-cycle strobe pattern from the instruction-class
// rules, and the DUT outputs are compared every cycle at the falling edge.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] IR;
  logic        MemReady;
  logic        PCout, Zlowout, ZHighout, MDRout;
  logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
  logic        IncPC, Read, Run, Illegal;
  logic [15:0] Rout, Rin;
  logic [4:0]  ALUop;

  typedef struct packed {
    logic        run;
    logic        ill;
    logic [4:0]  alu;
    logic [15:0] rin;
    logic [15:0] rout;
    logic pc_out, zlow_out, zhigh_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
    logic y_in, zlow_in, zhigh_in, hi_in, lo_in, inc_pc, read;
  } obs_t;

  typedef enum {C_BIN, C_UN, C_MD, C_HALT, C_ILL} cls_e;

  obs_t obs;
  assign obs = {Run, Illegal, ALUop, Rin, Rout, PCout, Zlowout, ZHighout, MDRout,
                MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, IncPC, Read};

  control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .MemReady(MemReady),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin), .ALUop(ALUop),
    .Run(Run), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  logic mr_q[$];
  int   t2_idx;

  logic [4:0] alu_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                               5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic obs_t quiet();
    obs_t e = '0;
    e.run = 1'b1;
    return e;
  endfunction

  function automatic logic [15:0] onehot(input logic [3:0] r);
    logic [15:0] one = 16'd1;
    return one << r;
  endfunction

  function automatic cls_e classify(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11)       return C_BIN;
    if (op == 5'd15 || op == 5'd16)      return C_MD;
    if (op == 5'd17 || op == 5'd18)      return C_UN;
    if (op == 5'd26)                     return C_HALT;
    return C_ILL;
  endfunction

  // Expected cycle-by-cycle pattern, from T0 up to (not including) next T0
  task automatic build(input logic [31:0] ir, input int waits);
    logic [4:0] op = ir[31:27];
    logic [3:0] ra = ir[26:23];
    logic [3:0] rb = ir[22:19];
    logic [3:0] rc = ir[18:15];
    cls_e       c  = classify(op);
    obs_t       e;
    exp_q.delete();
    mr_q.delete();
    e = quiet(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1;
    exp_q.push_back(e); mr_q.push_back(1'($urandom));
    for (int k = 0; k <= waits; k++) begin
      e = quiet(); e.read = 1; e.mdr_in = 1;
      exp_q.push_back(e); mr_q.push_back(k == waits);
    end
    e = quiet(); e.mdr_out = 1; e.ir_in = 1;
    t2_idx = exp_q.size();
    exp_q.push_back(e); mr_q.push_back(1'($urandom));
    case (c)
      C_BIN, C_MD, C_UN: begin
        e = quiet();
        if (c != C_UN) begin e.rout = onehot(rb); e.y_in = 1; end
        exp_q.push_back(e);
        e = quiet(); e.rout = onehot(c == C_UN ? rb : rc); e.alu = op;
        e.zlow_in = 1; e.zhigh_in = (c == C_MD);
        exp_q.push_back(e);
        e = quiet(); e.zlow_out = 1;
        if (c == C_MD) e.lo_in = 1;
        else           e.rin = (ra == 4'd0) ? 16'd0 : onehot(ra);
        exp_q.push_back(e);
        if (c == C_MD) begin
          e = quiet(); e.zhigh_out = 1; e.hi_in = 1;
          exp_q.push_back(e);
        end
      end
      C_HALT: begin
        e = '0;
        for (int k = 0; k < 5; k++) exp_q.push_back(e);
      end
      default: begin
        e = quiet(); e.ill = 1;
        exp_q.push_back(e);
      end
    endcase
    while (mr_q.size() < exp_q.size()) mr_q.push_back(1'($urandom));
  endtask

  // Assert Clear off-edge, check outputs at once, release and check IDLE
  task automatic do_reset(input string tag);
    Clear = 1'b0;
    #1;
    check({tag, "_rst"}, 64'(obs), 64'(quiet()));
    @(posedge Clock);
    #1 Clear = 1'b1;
    @(negedge Clock);
    check({tag, "_idle"}, 64'(obs), 64'(quiet()));
  endtask

  task automatic run_instr(input logic [31:0] ir, input int waits, input int abort_idx);
    build(ir, waits);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      check($sformatf("ir%08h_c%0d", ir, i), 64'(obs), 64'(exp_q[i]));
      check($sformatf("bus_excl_c%0d", i),
            64'($countones({PCout, Zlowout, ZHighout, MDRout, Rout}) <= 1), 64'(1));
      if (i == abort_idx) begin
        do_reset("abort");
        return;
      end
      MemReady = mr_q[i];
      if (i == 0) IR = $urandom;
      if (i == t2_idx) begin
        @(posedge Clock);
        #1 IR = ir;
      end
    end
    if (classify(ir[31:27]) == C_HALT) do_reset("halt");
  endtask

  initial begin
    logic [31:0] ir;
    logic [4:0]  op;
    int          r;
    Clear    = 1'b0;
    IR       = '0;
    MemReady = 1'b0;
    @(negedge Clock);
    do_reset("init");

    run_instr(32'h18918000, 0, 4);   // add R1,R2,R3 cut by reset in T4
    run_instr(32'h28918000, 0, -1);  // and R1,R2,R3
    run_instr(32'h8B380000, 0, -1);  // neg R6,R7
    run_instr(32'h28918000, 3, -1);  // and with three T1 wait cycles
    run_instr(32'h78228000, 0, -1);  // mul R0,R4,R5
    run_instr(32'hF8000000, 0, -1);  // undefined opcode
    run_instr(32'h18000000, 1, -1);  // add into R0: no Rin

    for (int n = 0; n < 80; n++) begin
      r  = int'($urandom_range(0, 99));
      ir = $urandom;
      if (r < 10) begin
        do op = 5'($urandom); while (classify(op) != C_ILL);
      end else if (r < 14) begin
        op = 5'd26;
      end else begin
        op = alu_ops[$urandom_range(0, 12)];
      end
      ir[31:27] = op;
      run_instr(ir, int'($urandom_range(0, 3)), -1);
    end

    run_instr(32'hD0000000, 0, -1);  // halt, then reset
    run_instr(32'h28918000, 0, -1);  // runs again after Clear

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
